// File: rtl/calc2_port_responder_if.sv
// rtl/calc2_port_responder_if.sv - request/response bundle for one calc2 port
interface calc2_port_responder_if;
  logic [3:0]  req_cmd_in;
  logic [31:0] req_data_in;
  logic [1:0]  req_tag_in;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic [1:0]  out_tag;
  logic        tag_err;

  modport master (
    output req_cmd_in, req_data_in, req_tag_in,
    input  out_resp, out_data, out_tag, tag_err
  );

  modport slave (
    input  req_cmd_in, req_data_in, req_tag_in,
    output out_resp, out_data, out_tag, tag_err
  );
endinterface

// File: rtl/calc2_port_responder.sv
// rtl/calc2_port_responder.sv - calc2 single-port responder: two-cycle capture,
// tag-indexed scoreboard with per-op latency, oldest-ready-first response emission
module calc2_port_responder #(
  parameter int LAT_ARITH = 3,
  parameter int LAT_SHIFT = 1
) (
  input logic                   c_clk,
  input logic                   reset,
  calc2_port_responder_if.slave port
);
  localparam logic [3:0] CMD_ADD = 4'h1;
  localparam logic [3:0] CMD_SUB = 4'h2;
  localparam logic [3:0] CMD_SHL = 4'h5;
  localparam logic [3:0] CMD_SHR = 4'h6;
  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  typedef enum logic {IDLE, OP2} state_t;
  state_t state, state_nxt;
  logic capture, write_en, collide, accept, tag_err_q;
  logic [3:0]  cmd_q;
  logic [1:0]  tag_q;
  logic [31:0] op1_q;

  logic [32:0] sum;
  logic [31:0] res_data;
  logic [1:0]  res_resp;
  logic [3:0]  res_lat;

  logic [3:0]  valid;
  logic [31:0] sb_data [4];
  logic [1:0]  sb_resp [4];
  logic [3:0]  sb_cnt [4];
  // older_than[i][j] set means entry j was captured before entry i
  logic [3:0]  older_than [4];
  logic [3:0]  ready;
  logic        emit_any;
  logic [1:0]  emit_sel;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    write_en  = 1'b0;
    case (state)
      IDLE: if (port.req_cmd_in != 4'h0) begin
        capture   = 1'b1;
        state_nxt = OP2;
      end
      OP2: begin
        write_en  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign collide = valid[tag_q];
  assign accept  = write_en && !collide;

  always_comb begin
    sum      = {1'b0, op1_q} + {1'b0, port.req_data_in};
    res_data = '0;
    res_resp = RESP_ERR;
    res_lat  = 4'(LAT_SHIFT);
    case (cmd_q)
      CMD_ADD: begin
        res_lat = 4'(LAT_ARITH);
        if (!sum[32]) begin
          res_data = sum[31:0];
          res_resp = RESP_OK;
        end
      end
      CMD_SUB: begin
        res_lat = 4'(LAT_ARITH);
        if (port.req_data_in <= op1_q) begin
          res_data = op1_q - port.req_data_in;
          res_resp = RESP_OK;
        end
      end
      CMD_SHL: begin
        res_data = op1_q << port.req_data_in[4:0];
        res_resp = RESP_OK;
      end
      CMD_SHR: begin
        res_data = op1_q >> port.req_data_in[4:0];
        res_resp = RESP_OK;
      end
      default: ;
    endcase
  end

  // Ready one cycle before the count hits zero so the response lands at T+1+LAT
  always_comb begin
    ready    = '0;
    emit_any = 1'b0;
    emit_sel = 2'd0;
    for (int i = 0; i < 4; i++) ready[i] = valid[i] && (sb_cnt[i] <= 4'd1);
    for (int i = 0; i < 4; i++) begin
      if (ready[i] && ((ready & older_than[i]) == 4'd0)) begin
        emit_any = 1'b1;
        emit_sel = 2'(i);
      end
    end
  end

  assign port.out_resp = emit_any ? sb_resp[emit_sel] : RESP_NONE;
  assign port.out_data = emit_any ? sb_data[emit_sel] : 32'd0;
  assign port.out_tag  = emit_any ? emit_sel : 2'd0;
  assign port.tag_err  = tag_err_q;

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state     <= IDLE;
      cmd_q     <= '0;
      tag_q     <= '0;
      op1_q     <= '0;
      valid     <= '0;
      tag_err_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        sb_data[i]    <= '0;
        sb_resp[i]    <= '0;
        sb_cnt[i]     <= '0;
        older_than[i] <= '0;
      end
    end else begin
      state     <= state_nxt;
      tag_err_q <= write_en && collide;
      if (capture) begin
        cmd_q <= port.req_cmd_in;
        tag_q <= port.req_tag_in;
        op1_q <= port.req_data_in;
      end
      for (int i = 0; i < 4; i++) begin
        if (valid[i] && sb_cnt[i] != 4'd0) sb_cnt[i] <= sb_cnt[i] - 4'd1;
        if (emit_any && emit_sel == 2'(i)) valid[i] <= 1'b0;
      end
      if (accept) begin
        valid[tag_q]      <= 1'b1;
        sb_data[tag_q]    <= res_data;
        sb_resp[tag_q]    <= res_resp;
        sb_cnt[tag_q]     <= res_lat;
        older_than[tag_q] <= valid;
        for (int j = 0; j < 4; j++) older_than[j][tag_q] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_calc2_port_responder.sv
// tb/tb_calc2_port_responder.sv - directed self-checking bench for calc2_port_responder
module tb_calc2_port_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [36:0] obs;

  logic        vr [16];
  logic [3:0]  vc [16];
  logic [31:0] vd [16];
  logic [1:0]  vt [16];
  logic [36:0] ve [16];

  calc2_port_responder_if bus ();

  calc2_port_responder #(.LAT_ARITH(3), .LAT_SHIFT(1)) dut (
    .c_clk (clk),
    .reset (rst),
    .port  (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [36:0] pk(input logic [1:0] r, input logic [31:0] d,
                                     input logic [1:0] t, input logic e);
    return {r, d, t, e};
  endfunction

  task automatic cyc(input logic r, input logic [3:0] c, input logic [31:0] d, input logic [1:0] t);
    rst = r;
    bus.req_cmd_in  = c;
    bus.req_data_in = d;
    bus.req_tag_in  = t;
    @(negedge clk);
    obs = {bus.out_resp, bus.out_data, bus.out_tag, bus.tag_err};
    @(posedge clk);
    #1;
  endtask

  task automatic clear_vec();
    for (int i = 0; i < 16; i++) begin
      vr[i] = 1'b0; vc[i] = '0; vd[i] = '0; vt[i] = '0; ve[i] = '0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_cmd_in = 4'h1; bus.req_data_in = 32'hFFFF_FFFF; bus.req_tag_in = 2'd3;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 4'h1, 32'hFFFF_FFFF, 2'd3);
      total++;
      if (obs !== 37'd0) begin
        bad++;
        $display("FAIL reset cycle %0d got %h want 0", i, obs);
      end
    end
    cyc(1'b0, 4'h0, 32'h0, 2'd0);
  endtask

  task automatic test_add();
    clear_vec();
    vc[0] = 4'h1; vd[0] = 32'h22; vt[0] = 2'd2; vd[1] = 32'h3;
    ve[4] = pk(2'd1, 32'h25, 2'd2, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(vr[i], vc[i], vd[i], vt[i]);
      total++;
      if (obs !== ve[i]) begin
        bad++;
        $display("FAIL add cycle %0d got %h want %h", i, obs, ve[i]);
      end
    end
  endtask

  task automatic test_sub();
    clear_vec();
    vc[0] = 4'h2; vd[0] = 32'h22; vt[0] = 2'd2; vd[1] = 32'h3;
    vc[2] = 4'h2; vd[2] = 32'h3;  vt[2] = 2'd1; vd[3] = 32'h22;
    ve[4] = pk(2'd1, 32'h1F, 2'd2, 1'b0);
    ve[6] = pk(2'd2, 32'h0, 2'd1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      cyc(vr[i], vc[i], vd[i], vt[i]);
      total++;
      if (obs !== ve[i]) begin
        bad++;
        $display("FAIL sub cycle %0d got %h want %h", i, obs, ve[i]);
      end
    end
  endtask

  task automatic test_edges();
    clear_vec();
    vc[0] = 4'h1; vd[0] = 32'hFFFF_FFFF; vt[0] = 2'd0; vd[1] = 32'h1;
    vc[4] = 4'h5; vd[4] = 32'h1;         vt[4] = 2'd1; vd[5] = 32'h21;
    vc[6] = 4'h6; vd[6] = 32'h8000_0000; vt[6] = 2'd2; vd[7] = 32'd31;
    vc[8] = 4'h3; vd[8] = 32'h1234;      vt[8] = 2'd3; vd[9] = 32'h5;
    ve[4]  = pk(2'd2, 32'h0, 2'd0, 1'b0);
    ve[6]  = pk(2'd1, 32'h2, 2'd1, 1'b0);
    ve[8]  = pk(2'd1, 32'h1, 2'd2, 1'b0);
    ve[10] = pk(2'd2, 32'h0, 2'd3, 1'b0);
    for (int i = 0; i < 12; i++) begin
      cyc(vr[i], vc[i], vd[i], vt[i]);
      total++;
      if (obs !== ve[i]) begin
        bad++;
        $display("FAIL edges cycle %0d got %h want %h", i, obs, ve[i]);
      end
    end
  endtask

  task automatic test_age_order();
    clear_vec();
    vc[0] = 4'h1; vd[0] = 32'h10; vt[0] = 2'd0; vd[1] = 32'h20;
    vc[2] = 4'h5; vd[2] = 32'h4;  vt[2] = 2'd1; vd[3] = 32'h1;
    ve[4] = pk(2'd1, 32'h30, 2'd0, 1'b0);
    ve[5] = pk(2'd1, 32'h8,  2'd1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(vr[i], vc[i], vd[i], vt[i]);
      total++;
      if (obs !== ve[i]) begin
        bad++;
        $display("FAIL age_order cycle %0d got %h want %h", i, obs, ve[i]);
      end
    end
  endtask

  task automatic test_out_of_order();
    clear_vec();
    vc[0] = 4'h5; vd[0] = 32'h4; vt[0] = 2'd1; vd[1] = 32'h2;
    vc[2] = 4'h1; vd[2] = 32'h5; vt[2] = 2'd0; vd[3] = 32'h6;
    ve[2] = pk(2'd1, 32'h10, 2'd1, 1'b0);
    ve[6] = pk(2'd1, 32'hB,  2'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(vr[i], vc[i], vd[i], vt[i]);
      total++;
      if (obs !== ve[i]) begin
        bad++;
        $display("FAIL out_of_order cycle %0d got %h want %h", i, obs, ve[i]);
      end
    end
  endtask

  task automatic test_tag_collision();
    clear_vec();
    vc[0] = 4'h1; vd[0] = 32'h1; vt[0] = 2'd3; vd[1] = 32'h2;
    vc[2] = 4'h1; vd[2] = 32'h7; vt[2] = 2'd3; vd[3] = 32'h8;
    ve[4] = pk(2'd1, 32'h3, 2'd3, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cyc(vr[i], vc[i], vd[i], vt[i]);
      total++;
      if (obs !== ve[i]) begin
        bad++;
        $display("FAIL collision cycle %0d got %h want %h", i, obs, ve[i]);
      end
    end
  endtask

  task automatic test_tag_reuse();
    clear_vec();
    vc[0] = 4'h1; vd[0] = 32'h1; vt[0] = 2'd0; vd[1] = 32'h1;
    vc[2] = 4'h1; vd[2] = 32'h9; vt[2] = 2'd0; vd[3] = 32'h9;
    vc[4] = 4'h1; vd[4] = 32'h3; vt[4] = 2'd0; vd[5] = 32'h4;
    ve[4] = pk(2'd1, 32'h2, 2'd0, 1'b1);
    ve[8] = pk(2'd1, 32'h7, 2'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(vr[i], vc[i], vd[i], vt[i]);
      total++;
      if (obs !== ve[i]) begin
        bad++;
        $display("FAIL reuse cycle %0d got %h want %h", i, obs, ve[i]);
      end
    end
  endtask

  task automatic test_reset_midop();
    clear_vec();
    vc[0] = 4'h1; vd[0] = 32'h5; vt[0] = 2'd0; vd[1] = 32'h6;
    vr[2] = 1'b1;
    vc[6] = 4'h5; vd[6] = 32'h3; vt[6] = 2'd2; vd[7] = 32'h1; vr[7] = 1'b1;
    for (int i = 0; i < 14; i++) begin
      cyc(vr[i], vc[i], vd[i], vt[i]);
      total++;
      if (obs !== ve[i]) begin
        bad++;
        $display("FAIL reset_midop cycle %0d got %h want %h", i, obs, ve[i]);
      end
    end
  endtask

  initial begin
    bus.req_cmd_in = '0; bus.req_data_in = '0; bus.req_tag_in = '0;
    test_reset();
    test_add();
    test_sub();
    test_edges();
    test_age_order();
    test_out_of_order();
    test_tag_collision();
    test_tag_reuse();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
